crank_cam_gen: RTL and testbench

Synthetic crankshaft/camshaft signal generator: the transmitter side of the angle-generator capture path. It produces a 60-2 crank tooth waveform and a 720°-phased cam waveform from a programmable tooth period. Used in-fabric as a stimulus source for the angle-generator core on bench and HIL builds, and as a loopback source in self-test.

---
 rtl/hwag_gen_pkg.sv | 26 ++
 rtl/tooth_slot_timer.sv | 58 +++++
 rtl/crank_cam_gen.sv | 125 ++++++++++++
 tb/tb_crank_cam_gen.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hwag_gen_pkg.sv
// Shared definitions for the synthetic crank/cam generator: tooth-wheel
// defaults, field widths, the idle/run state type and the cam window test.
package hwag_gen_pkg;

    localparam int TEETH_TOTAL_DEF   = 60;
    localparam int TEETH_MISSING_DEF = 2;
    localparam int PERIOD_MIN        = 4;
    localparam int SLOT_WIDTH        = 6;
    localparam int POS_WIDTH         = 7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } gen_state_e;

    // True when pos lies in [rise, fall), wrapping through the 720 degree
    // end when rise > fall; an empty window when rise == fall.
    function automatic logic cam_window(input logic [POS_WIDTH-1:0] pos,
                                        input logic [POS_WIDTH-1:0] rise,
                                        input logic [POS_WIDTH-1:0] fall);
        if (rise < fall)      return (pos >= rise) && (pos < fall);
        else if (rise > fall) return (pos >= rise) || (pos < fall);
        else                  return 1'b0;
    endfunction

endpackage

// File: rtl/tooth_slot_timer.sv
// Slot timer: period shadow (clamped), phase counter, tooth high-time and the
// slot-start strobe. start_o and high_o describe the cycle after the next edge
// so the top can register its outputs from them.
module tooth_slot_timer
    import hwag_gen_pkg::*;
#(
    parameter int PERIOD_WIDTH = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    go_i,       // run requested this cycle
    input  logic                    running_i,  // already running last cycle
    input  logic [PERIOD_WIDTH-1:0] period_i,
    output logic                    start_o,    // next cycle is phase 0 of a slot
    output logic                    high_o,     // next cycle lies in the tooth high time
    output logic                    ack_o       // registered period_ack
);

    localparam logic [PERIOD_WIDTH-1:0] ONE  = PERIOD_WIDTH'(1);
    localparam logic [PERIOD_WIDTH-1:0] PMIN = PERIOD_WIDTH'(PERIOD_MIN);

    logic [PERIOD_WIDTH-1:0] phase_q, phase_d;
    logic [PERIOD_WIDTH-1:0] shadow_q, shadow_d;
    logic [PERIOD_WIDTH-1:0] high_d;
    logic                    ack_q;

    // Phase/shadow next state; the shadow only moves at a slot start so a new
    // period never disturbs the slot in progress.
    always_comb begin
        start_o  = go_i && (!running_i || (phase_q == shadow_q - ONE));
        phase_d  = phase_q + ONE;
        shadow_d = shadow_q;
        if (!go_i) begin
            phase_d = '0;
        end else if (start_o) begin
            phase_d  = '0;
            shadow_d = (period_i < PMIN) ? PMIN : period_i;
        end
        high_d = shadow_d - (shadow_d >> 1);
        high_o = phase_d < high_d;
    end

    // Timer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= '0;
            shadow_q <= '0;
            ack_q    <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            shadow_q <= shadow_d;
            ack_q    <= start_o;
        end
    end

    assign ack_o = ack_q;

endmodule

// File: rtl/crank_cam_gen.sv
// 60-2 crank / 720 degree cam waveform generator.
// Optional cam output enabled by defining CRANK_CAM_GEN_CAM_EN; otherwise cam
// is tied low while rev still toggles every revolution.
module crank_cam_gen
    import hwag_gen_pkg::*;
#(
    parameter int TEETH_TOTAL   = TEETH_TOTAL_DEF,
    parameter int TEETH_MISSING = TEETH_MISSING_DEF,
    parameter int PERIOD_WIDTH  = 24,
    parameter int CAM_RISE_POS  = 5,
    parameter int CAM_FALL_POS  = 65
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    input  logic [PERIOD_WIDTH-1:0] period,
    output logic                    period_ack,
    output logic                    cap,
    output logic                    cam,
    output logic [SLOT_WIDTH-1:0]   slot_num,
    output logic                    rev,
    output logic                    gap_start
);

    localparam logic [SLOT_WIDTH-1:0] SLOT_LAST = SLOT_WIDTH'(TEETH_TOTAL - 1);
    localparam logic [SLOT_WIDTH-1:0] SLOT_GAP  = SLOT_WIDTH'(TEETH_TOTAL - TEETH_MISSING);

    if (CAM_RISE_POS < 0 || CAM_RISE_POS >= 2*TEETH_TOTAL ||
        CAM_FALL_POS < 0 || CAM_FALL_POS >= 2*TEETH_TOTAL ||
        TEETH_TOTAL > (1 << SLOT_WIDTH) || TEETH_MISSING >= TEETH_TOTAL) begin : g_param_err
        $error("crank_cam_gen: parameter out of range");
    end

    gen_state_e            state_q, state_d;
    logic [SLOT_WIDTH-1:0] slot_q, slot_d;
    logic                  rev_q, rev_d;
    logic                  cap_q, cap_d;
    logic                  cam_q, cam_d;
    logic                  gap_q, gap_d;
    logic                  slot_start;
    logic                  tooth_high;

    tooth_slot_timer #(
        .PERIOD_WIDTH (PERIOD_WIDTH)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .go_i      (ena),
        .running_i (state_q == ST_RUN),
        .period_i  (period),
        .start_o   (slot_start),
        .high_o    (tooth_high),
        .ack_o     (period_ack)
    );

    // Idle/run next state: ena alone decides; rst is applied in the register.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (ena)  state_d = ST_RUN;
            ST_RUN:  if (!ena) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Slot/rev advance and next output values for the cycle after the edge.
    always_comb begin
        slot_d = slot_q;
        rev_d  = rev_q;
        if (!ena) begin
            slot_d = '0;
            rev_d  = 1'b0;
        end else if (slot_start) begin
            if (state_q == ST_IDLE) begin
                slot_d = '0;
                rev_d  = 1'b0;
            end else if (slot_q == SLOT_LAST) begin
                slot_d = '0;
                rev_d  = ~rev_q;
            end else begin
                slot_d = slot_q + SLOT_WIDTH'(1);
            end
        end
        cap_d = ena && tooth_high && (slot_d < SLOT_GAP);
        gap_d = slot_start && (slot_d == SLOT_GAP);
    end

`ifdef CRANK_CAM_GEN_CAM_EN
    logic [POS_WIDTH-1:0] pos_d;

    // Cam level from the 720 degree slot position; pos only moves at slot starts.
    always_comb begin
        pos_d = POS_WIDTH'(slot_d) + (rev_d ? POS_WIDTH'(TEETH_TOTAL) : '0);
        cam_d = ena && cam_window(pos_d, POS_WIDTH'(CAM_RISE_POS), POS_WIDTH'(CAM_FALL_POS));
    end
`else
    assign cam_d = 1'b0;
`endif

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            slot_q  <= '0;
            rev_q   <= 1'b0;
            cap_q   <= 1'b0;
            cam_q   <= 1'b0;
            gap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            rev_q   <= rev_d;
            cap_q   <= cap_d;
            cam_q   <= cam_d;
            gap_q   <= gap_d;
        end
    end

    assign cap       = cap_q;
    assign cam       = cam_q;
    assign slot_num  = slot_q;
    assign rev       = rev_q;
    assign gap_start = gap_q;

endmodule

// File: tb/tb_crank_cam_gen.sv
// Bench for crank_cam_gen: per-cycle scoreboard against a slot model, a
// vector table of hand-derived checkpoints, and waveform-timing sequences.
module tb_crank_cam_gen;

    localparam int PW    = 24;
    localparam int CAM_R = 5;
    localparam int CAM_F = 65;
`ifdef CRANK_CAM_GEN_CAM_EN
    localparam bit CAMON = 1'b1;
`else
    localparam bit CAMON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, ena;
    logic [PW-1:0] period;
    logic          period_ack, cap, cam, rev, gap_start;
    logic [5:0]    slot_num;

    always #5 clk = ~clk;

    crank_cam_gen #(
        .TEETH_TOTAL   (60),
        .TEETH_MISSING (2),
        .PERIOD_WIDTH  (PW),
        .CAM_RISE_POS  (CAM_R),
        .CAM_FALL_POS  (CAM_F)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .period     (period),
        .period_ack (period_ack),
        .cap        (cap),
        .cam        (cam),
        .slot_num   (slot_num),
        .rev        (rev),
        .gap_start  (gap_start)
    );

    typedef struct packed {
        logic       cap;
        logic       cam;
        logic [5:0] slot;
        logic       rev;
        logic       ack;
        logic       gap;
    } out_t;

    typedef struct {
        logic r;
        logic e;
        int   p;
        int   n;
        out_t exp;
    } vec_t;

    vec_t tbl[$];
    out_t sb[$];
    int   acks[$];
    int   nvec = 0, nerr = 0, cyc = 0;

    // slot model state
    bit m_run, m_rev;
    int m_phase, m_P, m_slot;

    // waveform measurement state
    bit meas, prev_cap, prev_rev, prev_cam;
    int hi_len, lo_len, last_fall, last_gap, last_rtg, last_ack, cam_rises, exp_hi, exp_lo;

    function automatic out_t dut_out();
        return out_t'({cap, cam, slot_num, rev, period_ack, gap_start});
    endfunction

    function automatic bit cam_model(input int pos);
        if (!CAMON)        return 1'b0;
        if (CAM_R < CAM_F) return (pos >= CAM_R) && (pos < CAM_F);
        if (CAM_R > CAM_F) return (pos >= CAM_R) || (pos < CAM_F);
        return 1'b0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic meas_start(input int hi, input int lo);
        meas = 1'b1; exp_hi = hi; exp_lo = lo;
        prev_cap = cap; prev_rev = rev; prev_cam = cam;
        hi_len = 0; lo_len = 0; cam_rises = 0;
        last_fall = -1; last_gap = -1; last_rtg = -1; last_ack = -1;
    endtask

    task automatic observe();
        int p;
        p = exp_hi + exp_lo;
        if (cap) hi_len++; else lo_len++;
        if (prev_cap && !cap) begin
            chk("high_time", hi_len, exp_hi);
            if (last_fall >= 0) chk("fall_to_fall", cyc - last_fall, (m_slot == 0) ? 3*p : p);
            last_fall = cyc; hi_len = 0;
        end
        if (!prev_cap && cap) begin
            if (m_slot != 0) chk("low_time", lo_len, exp_lo);
            lo_len = 0;
        end
        if (period_ack) begin
            if (last_ack >= 0) chk("ack_interval", cyc - last_ack, p);
            last_ack = cyc;
        end
        if (gap_start) begin
            chk("gap_slot", int'(slot_num), 58);
            if (last_gap >= 0) chk("gap_interval", cyc - last_gap, 60*p);
            last_gap = cyc;
        end
        if (rev != prev_rev) begin
            if (last_rtg >= 0) chk("rev_interval", cyc - last_rtg, 60*p);
            last_rtg = cyc;
        end
        if (cam && !prev_cam) begin
            cam_rises++;
            chk("cam_rise_at", int'({rev, slot_num}), 5);
        end
        if (!cam && prev_cam) chk("cam_fall_at", int'({rev, slot_num}), 64 + 5);
        prev_cap = cap; prev_rev = rev; prev_cam = cam;
    endtask

    // Drive one cycle, push the model's expectation, compare after the edge.
    task automatic step(input logic r, input logic e, input int p);
        out_t x;
        rst = r; ena = e; period = PW'(p);
        x = '0;
        if (r || !e) begin
            m_run = 1'b0; m_phase = 0; m_slot = 0; m_rev = 1'b0;
        end else begin
            if (!m_run) begin
                m_run = 1'b1; x.ack = 1'b1; m_slot = 0; m_rev = 1'b0;
            end else if (m_phase == m_P - 1) begin
                x.ack = 1'b1;
                if (m_slot == 59) begin m_slot = 0; m_rev = ~m_rev; end
                else m_slot++;
            end else begin
                m_phase++;
            end
            if (x.ack) begin m_phase = 0; m_P = (p < 4) ? 4 : p; end
            x.gap  = x.ack && (m_slot == 58);
            x.cap  = (m_slot < 58) && (m_phase < m_P - m_P/2);
            x.cam  = cam_model(m_rev*60 + m_slot);
            x.slot = 6'(m_slot);
            x.rev  = m_rev;
        end
        sb.push_back(x);
        @(posedge clk);
        #1;
        cyc++;
        chk("cycle", int'(dut_out()), int'(sb.pop_front()));
        if (meas) observe();
    endtask

    task automatic add(input logic r, input logic e, input int p, input int n,
                       input logic c_cap, input logic c_cam, input int c_slot,
                       input logic c_rev, input logic c_ack, input logic c_gap);
        vec_t v;
        v.r = r; v.e = e; v.p = p; v.n = n;
        v.exp = out_t'({c_cap, c_cam, 6'(c_slot), c_rev, c_ack, c_gap});
        tbl.push_back(v);
    endtask

    initial begin
        rst = 1'b1; ena = 1'b0; period = PW'(10); meas = 1'b0;
        m_run = 1'b0; m_rev = 1'b0; m_phase = 0; m_P = 4; m_slot = 0;

        // r  e  p   n    cap cam    slot rev ack gap
        add(1, 0, 10, 3,   0, 0,     0,   0,  0,  0);  // reset state
        add(0, 1, 10, 1,   1, 0,     0,   0,  1,  0);  // first cycle after enable
        add(0, 1, 10, 5,   0, 0,     0,   0,  0,  0);  // phase 5: low half
        add(0, 1, 10, 4,   0, 0,     0,   0,  0,  0);  // phase 9: last of slot 0
        add(0, 1, 10, 1,   1, 0,     1,   0,  1,  0);  // slot 1 start
        add(0, 1, 10, 570, 0, CAMON, 58,  0,  1,  1);  // first missing slot
        add(0, 1, 10, 20,  1, CAMON, 0,   1,  1,  0);  // wrap, rev toggles
        add(0, 1, 1,  10,  1, CAMON, 1,   1,  1,  0);  // period 1 latched as 4
        add(0, 1, 1,  2,   0, CAMON, 1,   1,  0,  0);  // 2 high done
        add(0, 1, 1,  2,   1, CAMON, 2,   1,  1,  0);  // 4-cycle slot
        add(0, 0, 1,  1,   0, 0,     0,   0,  0,  0);  // ena low -> idle
        add(0, 1, 7,  1,   1, 0,     0,   0,  1,  0);  // restart, P=7
        add(0, 1, 7,  4,   0, 0,     0,   0,  0,  0);  // phase 4: H=4 over
        add(0, 1, 7,  3,   1, 0,     1,   0,  1,  0);  // 7-cycle slot
        add(1, 1, 7,  1,   0, 0,     0,   0,  0,  0);  // rst beats ena
        add(0, 1, 10, 1,   1, 0,     0,   0,  1,  0);  // restart after rst

        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].n; k++) step(tbl[i].r, tbl[i].e, tbl[i].p);
            chk($sformatf("vec%0d", i), int'(dut_out()), int'(tbl[i].exp));
        end

        // Constant P=10 for two revolutions: tooth widths, gap, rev, cam.
        step(1, 0, 10);
        meas_start(5, 5);
        for (int i = 0; i < 1230; i++) step(0, 1, 10);
        meas = 1'b0;
        chk("gap_seen", (last_gap >= 0) ? 1 : 0, 1);
        chk("cam_rises", cam_rises, CAMON ? 1 : 0);

        // Clamped period and odd period high/low split.
        step(1, 0, 1);
        meas_start(2, 2);
        for (int i = 0; i < 100; i++) step(0, 1, 1);
        meas = 1'b0;
        step(1, 0, 7);
        meas_start(4, 3);
        for (int i = 0; i < 100; i++) step(0, 1, 7);
        meas = 1'b0;

        // Period change in the middle of slot 3.
        step(1, 0, 10);
        acks.delete();
        for (int i = 0; i < 80; i++) begin
            step(0, 1, (i >= 34) ? 20 : 10);
            if (period_ack) acks.push_back(i);
        end
        chk("ack_count", acks.size(), 6);
        if (acks.size() >= 6) begin
            chk("slot3_len", acks[4] - acks[3], 10);
            chk("slot4_len", acks[5] - acks[4], 20);
        end

        // ena dropped at slot 20 phase 3, then re-enabled.
        step(1, 0, 10);
        for (int i = 0; i < 204; i++) step(0, 1, 10);
        chk("pre_drop_slot", int'(slot_num), 20);
        step(0, 0, 10);
        chk("ena_drop_idle", int'(dut_out()), 0);
        step(0, 1, 10);
        chk("ena_restart", int'(dut_out()), int'(out_t'({1'b1, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0})));

        // rst pulsed mid-run, then released.
        for (int i = 0; i < 77; i++) step(0, 1, 10);
        step(1, 1, 10);
        chk("rst_idle", int'(dut_out()), 0);
        step(0, 1, 10);
        chk("rst_restart", int'(dut_out()), int'(out_t'({1'b1, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0})));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
